harness_output_serializer: RTL and testbench
============================================

# harness_output_serializer

Test-harness block that captures a parallel DUT result word and shifts it out one bit per accepted cycle on a single pin, with a valid/ready handshake on the serial side. It is the parallel-to-serial counterpart of the harness input register: it lets a WIDTH-bit DUT output leave the harness on one FPGA pin. The bit order and the framing (`out_last`) are defined exactly, so a bench or an off-chip capture can rebuild the word.

## Interface
- `WIDTH`, 36, word width in bits; WIDTH >= 2.
- `MSB_FIRST`, 1, 1: bit WIDTH-1 is sent first; 0: bit 0 is sent first.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in`  in  WIDTH  parallel word from the DUT.
- `wren`  in  1  load request; the word is captured when `wren && ready`.
- `ready`  out  1  the block can accept a load this cycle (combinational).
- `out`  out  1  serial data bit (registered).
- `out_valid`  out  1  `out` holds a valid bit (registered).
- `out_last`  out  1  the current bit is the final bit of the word (registered).
- `out_ready`  in  1  the consumer accepts the current bit when `out_valid && out_ready`.

## Operation
- State: FSM {IDLE, SHIFT}, shift register `sr[WIDTH-1:0]`, down-counter `cnt` of width clog2(WIDTH).
- Reset (asynchronous, while `reset_n`=0):
  - state=IDLE, sr=0, cnt=0.
  - `out`=0, `out_valid`=0, `out_last`=0.
  - `ready` follows state, so it reads 1.
- `ready` = (state==IDLE) | (state==SHIFT & `out_last` & `out_ready`).
- A load (`wren && ready`) does the following:
  - sr <= `in`, cnt <= WIDTH-1, state <= SHIFT.
  - `out` <= in[WIDTH-1] if MSB_FIRST, else in[0].
  - `out_last` <= 0.
- A transfer is `out_valid && out_ready` in SHIFT with cnt != 0. On a transfer:
  - MSB_FIRST: sr shifts left, zero-filled.
  - LSB_FIRST: sr shifts right, zero-filled.
  - cnt decrements.
  - `out` <= the next bit.
  - `out_last` <= (cnt==1).
- Final transfer (`out_last && out_ready`):
  - With no simultaneous load: state <= IDLE, `out_valid` <= 0, `out_last` <= 0, and `out` holds its value.
  - With a simultaneous load: the load wins. The new word loads as described above, state stays SHIFT and `out_valid` stays 1, so there is no bubble.
- Without `out_ready`, `out`, `out_valid` and `out_last` hold indefinitely. The word is never dropped or reordered.
- `wren` while `ready`=0 is ignored. No error flag is raised, and the caller must re-request.
- `in` is sampled only on the load edge. Later changes to `in` do not affect a word in flight.
- `out_valid`=1 exactly while state==SHIFT.

## Timing
- Load-to-first-bit latency: 1 cycle. A load at edge N gives `out_valid`=1 after edge N.
- Throughput with `out_ready` held at 1 is one bit per cycle.
  - A word occupies exactly WIDTH cycles of `out_valid`.
  - Back-to-back words with `wren` held at 1 give continuous `out_valid`, with `out_last` every WIDTH cycles.
- `ready` depends combinationally on `out_ready`. There is no combinational path from `wren` or `in` to any output.
- Asserting reset mid-word aborts the word immediately; no partial bits follow reset release.
- First load after reset release: 1 cycle after `reset_n` rises, provided reset was released synchronously to `clock`.

## Test plan
Benches use WIDTH=8.
- Reset: hold `reset_n`=0 with `wren`=1 and `in`=8'hFF -> `out_valid`=0, `out`=0, `out_last`=0, `ready`=1, and no load occurs.
- Single word: MSB_FIRST=1, load 8'hA5, `out_ready`=1.
  - `out` sequence is 1,0,1,0,0,1,0,1 on the 8 cycles after the load.
  - `out_last`=1 only on the 8th cycle, then `out_valid`=0 and `ready`=1.
- LSB order: MSB_FIRST=0, load 8'h01 -> `out` sequence is 1,0,0,0,0,0,0,0.
- Back-to-back: `wren`=1 continuously, in=8'hF0 then 8'h0F, `out_ready`=1.
  - 16 consecutive valid cycles: 1111000000001111.
  - `out_last` on cycles 8 and 16.
  - `ready` is high only on the cycles of those two loads.
- Backpressure: load 8'h81, toggle `out_ready` 1,0,0,1,...
  - Bits hold during the stalls and the sequence is still 1,0,0,0,0,0,0,1.
  - `wren` pulsed mid-word is ignored.
- Reset mid-word: load 8'hFF, assert `reset_n`=0 after 3 bits -> outputs go to 0 asynchronously, and after release `out_valid` stays 0 until a new load.

Source files
------------

// File: rtl/harness_output_serializer.sv
// Parallel-to-serial output stage for the test harness: captures a WIDTH-bit word on
// wren && ready and shifts it out one bit per accepted cycle with valid/ready/last framing.
module harness_output_serializer #(
   parameter int unsigned WIDTH     = 36,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   input  logic             wren,
   output logic             ready,
   output logic             out,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;

   logic load;
   logic xfer;
   logic final_xfer;

   // A load is also accepted on the cycle the last bit leaves, so words can run back to back.
   assign ready      = (state == IDLE) | ((state == SHIFT) & out_last & out_ready);
   assign load       = wren & ready;
   assign xfer       = (state == SHIFT) & out_valid & out_ready & (cnt != '0);
   assign final_xfer = (state == SHIFT) & out_last & out_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         sr        <= '0;
         cnt       <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (load) begin
         state     <= SHIFT;
         sr        <= in;
         cnt       <= CW'(WIDTH - 1);
         out       <= MSB_FIRST ? in[WIDTH-1] : in[0];
         out_valid <= 1'b1;
         out_last  <= 1'b0;
      end else if (xfer) begin
         // The presented bit always sits at the leading end of sr; the next one is beside it.
         if (MSB_FIRST) begin
            sr  <= {sr[WIDTH-2:0], 1'b0};
            out <= sr[WIDTH-2];
         end else begin
            sr  <= {1'b0, sr[WIDTH-1:1]};
            out <= sr[1];
         end
         cnt      <= cnt - CW'(1);
         out_last <= (cnt == CW'(1));
      end else if (final_xfer) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_harness_output_serializer.sv
// Bench for harness_output_serializer (WIDTH=8, both bit orders side by side) against a
// word/index reference model, plus literal checks on the reassembled serial streams.
module tb_harness_output_serializer;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] in = '0;
   logic       wren = 1'b0;
   logic       out_ready = 1'b0;

   logic ready_a, out_a, valid_a, last_a;
   logic ready_b, out_b, valid_b, last_b;

   int checks = 0;
   int errors = 0;

   harness_output_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
      .clock(clock), .reset_n(reset_n), .in(in), .wren(wren), .ready(ready_a),
      .out(out_a), .out_valid(valid_a), .out_last(last_a), .out_ready(out_ready)
   );

   harness_output_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
      .clock(clock), .reset_n(reset_n), .in(in), .wren(wren), .ready(ready_b),
      .out(out_b), .out_valid(valid_b), .out_last(last_b), .out_ready(out_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the word in flight and how many of its bits have been accepted.
   logic       m_busy = 1'b0;
   logic [7:0] m_word = '0;
   int         m_idx = 0;
   logic       m_hold_a = 1'b0;
   logic       m_hold_b = 1'b0;

   function automatic logic exp_ready();
      return !m_busy || (m_idx == 7 && out_ready);
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_word = '0; m_idx = 0; m_hold_a = 1'b0; m_hold_b = 1'b0;
   endtask

   always @(negedge reset_n) model_reset();

   always @(posedge clock) begin
      if (!reset_n) begin
         model_reset();
      end else begin
         logic ld;
         ld = wren && exp_ready();
         if (m_busy && out_ready) begin
            if (m_idx == 7) begin
               m_hold_a = m_word[0];
               m_hold_b = m_word[7];
               m_busy   = 1'b0;
            end else begin
               m_idx++;
            end
         end
         if (ld) begin
            m_word = in; m_idx = 0; m_busy = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      logic eo_a, eo_b;
      eo_a = m_busy ? m_word[7 - m_idx] : m_hold_a;
      eo_b = m_busy ? m_word[m_idx] : m_hold_b;
      chk("ready_a", ready_a, exp_ready());
      chk("ready_b", ready_b, exp_ready());
      chk("valid_a", valid_a, m_busy);
      chk("valid_b", valid_b, m_busy);
      chk("last_a", last_a, m_busy && m_idx == 7);
      chk("last_b", last_b, m_busy && m_idx == 7);
      chk("out_a", out_a, eo_a);
      chk("out_b", out_b, eo_b);
   end

   // Reassemble the serial streams: first accepted bit ends up most significant.
   logic [31:0] col_a = '0, col_b = '0;
   int          n_a = 0, n_b = 0, loads = 0;

   always @(posedge clock) begin
      if (reset_n) begin
         if (valid_a && out_ready) begin col_a = {col_a[30:0], out_a}; n_a++; end
         if (valid_b && out_ready) begin col_b = {col_b[30:0], out_b}; n_b++; end
         if (wren && ready_a) loads++;
      end
   end

   task automatic clear_col();
      col_a = '0; col_b = '0; n_a = 0; n_b = 0; loads = 0;
   endtask

   task automatic step();
      @(posedge clock); #1;
   endtask

   initial begin
      logic [3:0] pat;
      pat = 4'b1001;

      // Reset held with a load request pending
      reset_n = 1'b0; wren = 1'b1; in = 8'hFF; out_ready = 1'b1;
      repeat (3) step();
      chk("rst_ready", ready_a, 1'b1);
      chk("rst_valid", valid_a, 1'b0);
      chk("rst_out", out_a, 1'b0);
      wren = 1'b0; reset_n = 1'b1;
      step();

      // Single word 8'hA5
      clear_col();
      wren = 1'b1; in = 8'hA5; step();
      wren = 1'b0; in = 8'h00;
      repeat (12) step();
      chk("a5_count", n_a, 8);
      chk("a5_msb", col_a[7:0], 8'hA5);
      chk("a5_lsb", col_b[7:0], 8'hA5);
      chk("a5_ready", ready_a, 1'b1);

      // 8'h01 shows the two bit orders
      clear_col();
      wren = 1'b1; in = 8'h01; step();
      wren = 1'b0;
      repeat (12) step();
      chk("01_msb", col_a[7:0], 8'h01);
      chk("01_lsb", col_b[7:0], 8'h80);

      // Back-to-back words with wren held
      clear_col();
      wren = 1'b1; in = 8'hF0; step();
      in = 8'h0F;
      repeat (8) step();
      wren = 1'b0;
      repeat (12) step();
      chk("b2b_count", n_a, 16);
      chk("b2b_loads", loads, 2);
      chk("b2b_msb", col_a[15:0], 16'hF00F);
      chk("b2b_lsb", col_b[15:0], 16'h0FF0);

      // Backpressure with an ignored mid-word load request
      clear_col();
      wren = 1'b1; in = 8'h81; out_ready = 1'b1; step();
      for (int i = 0; i < 40; i++) begin
         out_ready = pat[3 - (i % 4)];
         wren = (i == 5);
         in = (i == 5) ? 8'hFF : 8'h00;
         step();
      end
      wren = 1'b0; out_ready = 1'b1;
      repeat (10) step();
      chk("bp_count", n_a, 8);
      chk("bp_loads", loads, 1);
      chk("bp_msb", col_a[7:0], 8'h81);
      chk("bp_lsb", col_b[7:0], 8'h81);

      // Reset in the middle of a word
      clear_col();
      wren = 1'b1; in = 8'hFF; step();
      wren = 1'b0;
      repeat (3) step();
      chk("mid_bits", n_a, 3);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_valid", valid_a, 1'b0);
      chk("mid_out", out_a, 1'b0);
      chk("mid_last", last_b, 1'b0);
      step();
      reset_n = 1'b1;
      repeat (5) step();
      chk("mid_after", valid_a, 1'b0);
      chk("mid_bits2", n_a, 3);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         wren = ($urandom_range(0, 3) == 0);
         in = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         reset_n = !(i >= 1500 && i < 1502);
         step();
      end
      wren = 1'b0; out_ready = 1'b1;
      repeat (12) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
